// File: rtl/nw_pkg.sv
// Shared Needleman-Wunsch definitions: arrow symbols, nucleotide codes and traceback FSM states.
// Used by the fill engine, the traceback walker and the aligned-output stage.
package nw_pkg;

  localparam logic [2:0] SYM_NONE = 3'b000;
  localparam logic [2:0] SYM_DIAG = 3'b001;
  localparam logic [2:0] SYM_UP   = 3'b010;
  localparam logic [2:0] SYM_LEFT = 3'b100;
  localparam logic [2:0] DASH     = 3'b111;

  localparam logic [2:0] NT_A = 3'b001;
  localparam logic [2:0] NT_C = 3'b010;
  localparam logic [2:0] NT_G = 3'b011;
  localparam logic [2:0] NT_T = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LATCH,
    ST_EMIT,
    ST_FIN
  } tb_state_t;

endpackage

// File: rtl/traceback_walker.sv
// Walks the direction matrix from (len_a,len_b) to (0,0), one arrow plus characters every 3 cycles.
// No backpressure: downstream stage consumes symbol_out in the single cycle it is nonzero.
module traceback_walker
  import nw_pkg::*;
#(
  parameter int N  = 128,
  parameter int IW = $clog2(N + 1),
  parameter int CW = $clog2(2 * N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [IW-1:0] len_a,
  input  logic [IW-1:0] len_b,
  output logic [IW-1:0] dir_i,
  output logic [IW-1:0] dir_j,
  input  logic [2:0]    dir_data,
  output logic [IW-1:0] seqA_addr,
  input  logic [2:0]    seqA_data,
  output logic [IW-1:0] seqB_addr,
  input  logic [2:0]    seqB_data,
  output logic [2:0]    symbol_out,
  output logic [2:0]    SeqA_i_t,
  output logic [2:0]    SeqB_j_t,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [CW-1:0] step_count
);

  tb_state_t     state;
  logic [IW-1:0] i, j;
  logic [2:0]    move_sel;
  logic          move_ok;
  logic          dec_i, dec_j;
  logic [IW-1:0] i_nxt, j_nxt;

  // On a matrix edge only one move is geometrically possible, so RAM data is ignored there.
  function automatic logic [2:0] pick_move(input logic [IW-1:0] ci, input logic [IW-1:0] cj,
                                           input logic [2:0] d);
    if (ci == '0) return SYM_LEFT;
    if (cj == '0) return SYM_UP;
    return d;
  endfunction

  assign dir_i     = i;
  assign dir_j     = j;
  assign seqA_addr = (i != '0) ? i - IW'(1) : '0;
  assign seqB_addr = (j != '0) ? j - IW'(1) : '0;

  always_comb begin
    move_sel = pick_move(i, j, dir_data);
    move_ok  = (move_sel == SYM_DIAG) || (move_sel == SYM_UP) || (move_sel == SYM_LEFT);
    dec_i    = (symbol_out == SYM_DIAG) || (symbol_out == SYM_UP);
    dec_j    = (symbol_out == SYM_DIAG) || (symbol_out == SYM_LEFT);
    i_nxt    = (dec_i && i != '0) ? i - IW'(1) : i;
    j_nxt    = (dec_j && j != '0) ? j - IW'(1) : j;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      i          <= '0;
      j          <= '0;
      symbol_out <= SYM_NONE;
      SeqA_i_t   <= '0;
      SeqB_j_t   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      step_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            i          <= len_a;
            j          <= len_b;
            error      <= 1'b0;
            step_count <= '0;
            if (len_a > IW'(N) || len_b > IW'(N)) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= ST_FIN;
            end else if (len_a == '0 && len_b == '0) begin
              done  <= 1'b1;
              state <= ST_FIN;
            end else begin
              busy  <= 1'b1;
              state <= ST_READ;
            end
          end
        end
        ST_READ: state <= ST_LATCH;
        ST_LATCH: begin
          if (move_ok) begin
            symbol_out <= move_sel;
            SeqA_i_t   <= (i == '0) ? 3'b000 : seqA_data;
            SeqB_j_t   <= (j == '0) ? 3'b000 : seqB_data;
            state      <= ST_EMIT;
          end else begin
            error <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_FIN;
          end
        end
        ST_EMIT: begin
          symbol_out <= SYM_NONE;
          step_count <= step_count + CW'(1);
          i          <= i_nxt;
          j          <= j_nxt;
          if (i_nxt == '0 && j_nxt == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_FIN;
          end else begin
            state <= ST_READ;
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_traceback_walker.sv
// Directed bench for traceback_walker with behavioural 1-cycle-latency RAMs.
module tb_traceback_walker;
  import nw_pkg::*;

  localparam int N  = 128;
  localparam int IW = $clog2(N + 1);
  localparam int CW = $clog2(2 * N + 1);

  logic          clk = 1'b0;
  logic          rst, start;
  logic [IW-1:0] len_a, len_b;
  logic [IW-1:0] dir_i, dir_j, seqA_addr, seqB_addr;
  logic [2:0]    dir_data, seqA_data, seqB_data;
  logic [2:0]    symbol_out, SeqA_i_t, SeqB_j_t;
  logic          busy, done, error;
  logic [CW-1:0] step_count;

  traceback_walker #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .len_a(len_a), .len_b(len_b),
    .dir_i(dir_i), .dir_j(dir_j), .dir_data(dir_data),
    .seqA_addr(seqA_addr), .seqA_data(seqA_data),
    .seqB_addr(seqB_addr), .seqB_data(seqB_data),
    .symbol_out(symbol_out), .SeqA_i_t(SeqA_i_t), .SeqB_j_t(SeqB_j_t),
    .busy(busy), .done(done), .error(error), .step_count(step_count)
  );

  always #5 clk = ~clk;

  logic [2:0] dir_mem  [0:N][0:N];
  logic [2:0] seqa_mem [0:N];
  logic [2:0] seqb_mem [0:N];

  always @(posedge clk) begin
    dir_data  <= dir_mem[dir_i][dir_j];
    seqA_data <= seqa_mem[seqA_addr];
    seqB_data <= seqb_mem[seqB_addr];
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt, done_cyc, rise_cyc;
  logic busy_q = 1'b0;
  int sym_q[$], a_q[$], b_q[$], baddr_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (symbol_out != 3'b000) begin
      sym_q.push_back(int'(symbol_out));
      a_q.push_back(int'(SeqA_i_t));
      b_q.push_back(int'(SeqB_j_t));
      baddr_q.push_back(int'(seqB_addr));
    end
    if (busy && !busy_q) rise_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    busy_q = busy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic go(input int la, input int lb);
    sym_q.delete(); a_q.delete(); b_q.delete(); baddr_q.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    len_a = IW'(la); len_b = IW'(lb); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k = 0;
    while (done_cnt == 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check({tag, " done"}, done_cnt, 1);
  endtask

  task automatic check_steps(input string tag, input int es[$], input int ea[$], input int eb[$]);
    check({tag, " nsym"}, sym_q.size(), es.size());
    for (int k = 0; k < es.size(); k++) begin
      check($sformatf("%s sym%0d", tag, k), sym_q[k], es[k]);
      check($sformatf("%s a%0d", tag, k), a_q[k], ea[k]);
      check($sformatf("%s b%0d", tag, k), b_q[k], eb[k]);
    end
  endtask

  initial begin
    for (int r = 0; r <= N; r++) begin
      for (int c = 0; c <= N; c++) dir_mem[r][c] = 3'b000;
      seqa_mem[r] = 3'b000;
      seqb_mem[r] = 3'b000;
    end
    seqa_mem[0] = 3'd1; seqa_mem[1] = 3'd2; seqa_mem[2] = 3'd3; seqa_mem[3] = 3'd4;
    seqb_mem[0] = 3'd4; seqb_mem[1] = 3'd3; seqb_mem[2] = 3'd2; seqb_mem[3] = 3'd1;

    rst = 1'b1; start = 1'b0; len_a = '0; len_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst sym", symbol_out, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", error, 0);
    check("rst cnt", step_count, 0);
    check("rst dir_i", dir_i, 0);
    rst = 1'b0;

    // Reset mid-walk: aborts with no done pulse
    dir_mem[3][3] = SYM_DIAG; dir_mem[2][2] = SYM_DIAG; dir_mem[1][1] = SYM_DIAG;
    go(3, 3);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check("t1 sym", symbol_out, 0);
    check("t1 busy", busy, 0);
    check("t1 cnt", step_count, 0);
    check("t1 dir_i", dir_i, 0);
    check("t1 seqa", SeqA_i_t, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("t1 no done", done_cnt, 0);
    check("t1 idle busy", busy, 0);

    // 2x2, two diagonals
    go(2, 2);
    wait_done("t2", 20);
    check_steps("t2", '{1, 1}, '{2, 1}, '{3, 4});
    check("t2 cnt", step_count, 2);
    check("t2 lat", done_cyc - rise_cyc, 6);
    check("t2 err", error, 0);

    // 3x1: UP, DIAG, then forced UP despite illegal RAM content
    dir_mem[3][1] = SYM_UP; dir_mem[2][1] = SYM_DIAG; dir_mem[1][0] = 3'b011;
    go(3, 1);
    wait_done("t3", 30);
    check_steps("t3", '{2, 1, 2}, '{3, 2, 1}, '{4, 4, 0});
    check("t3 cnt", step_count, 3);
    check("t3 err", error, 0);

    // 0x4: forced LEFT along row 0
    for (int c = 0; c <= 4; c++) dir_mem[0][c] = SYM_DIAG;
    go(0, 4);
    wait_done("t4", 30);
    check_steps("t4", '{4, 4, 4, 4}, '{0, 0, 0, 0}, '{1, 2, 3, 4});
    for (int k = 0; k < 4; k++) check($sformatf("t4 baddr%0d", k), baddr_q[k], 3 - k);
    check("t4 cnt", step_count, 4);
    check("t4 err", error, 0);

    // Illegal code at (2,2) after one step; start during busy ignored
    dir_mem[2][2] = 3'b011;
    go(3, 3);
    @(posedge clk); #1;
    len_a = IW'(1); len_b = IW'(1); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t5", 30);
    check_steps("t5", '{1}, '{3}, '{2});
    check("t5 err", error, 1);
    check("t5 cnt", step_count, 1);
    repeat (10) @(negedge clk);
    check("t5 one done", done_cnt, 1);
    check("t5 err sticky", error, 1);

    // 0x0 clears error, no steps
    go(0, 0);
    wait_done("t6a", 3);
    check("t6a err", error, 0);
    check("t6a cnt", step_count, 0);
    check("t6a nsym", sym_q.size(), 0);

    // Out-of-range length
    go(N + 1, 0);
    wait_done("t6b", 2);
    check("t6b err", error, 1);
    check("t6b nsym", sym_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
